// File: rtl/exec_pkg.sv
// Shared constants for the execute/writeback stage: default widths, opcodes, FSM states.
package exec_pkg;

    localparam int BITS_DEF  = 16;
    localparam int RBITS_DEF = 3;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_MOV = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/exec_unit_mul_seq.sv
// Sequential shift-add multiplier, one iteration per run-high cycle; done_o flags the
// final iteration and product_o carries the finished low-half product in that cycle.
module mul_seq #(
    parameter int BITS   = 16,
    parameter int CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run_i,
    input  logic            start_i,
    input  logic [BITS-1:0] a_i,
    input  logic [BITS-1:0] b_i,
    output logic            done_o,
    output logic [BITS-1:0] product_o
);
    localparam int CW = $clog2(CYCLES);

    logic [BITS-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, step;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;

    assign step      = acc_q + (b_q[0] ? a_q : '0);
    assign done_o    = busy_q && (cnt_q == CW'(CYCLES - 1));
    assign product_o = step;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            a_d    = a_i;
            b_d    = b_i;
            acc_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            acc_d  = step;
            a_d    = a_q << 1;
            b_d    = b_q >> 1;
            cnt_d  = cnt_q + 1'b1;
            busy_d = !done_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (run_i) begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Execute/writeback stage feeding the register file write port and condition flags.
// Optional multiply built when EXEC_MUL_EN is defined; otherwise opcode 9 is a NOP.
//   state   | meaning
//   ST_IDLE | accepting ops, single-cycle results written next cycle
//   ST_MUL  | multiply iterating, issue stalled
module exec_unit
    import exec_pkg::*;
#(
    parameter int BITS       = BITS_DEF,
    parameter int RBITS      = RBITS_DEF,
    parameter int MUL_CYCLES = BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic             issue_valid_i,
    output logic             issue_ready_o,
    input  logic [3:0]       op_i,
    input  logic [RBITS-1:0] rd_in_i,
    input  logic [BITS-1:0]  rs1_val_i,
    input  logic [BITS-1:0]  rs2_val_i,
    input  logic [BITS-1:0]  imm_i,
    input  logic             use_imm_i,
    output logic             we_o,
    output logic [RBITS-1:0] rd_o,
    output logic [BITS-1:0]  rd_din_o,
    output logic             flag_z_o,
    output logic             flag_n_o,
    output logic             flag_c_o
);
    if (MUL_CYCLES != BITS) begin : g_bad_cfg
        $error("exec_unit: MUL_CYCLES must equal BITS");
    end

    logic [BITS-1:0]  b_op, alu_res, rd_din_q, rd_din_d;
    logic [RBITS-1:0] rd_q, rd_d;
    logic             alu_c, alu_wr, accept;
    logic             we_q, we_d, z_q, z_d, n_q, n_d, c_q, c_d;

    assign accept = run_i & issue_valid_i & issue_ready_o;
    assign b_op   = use_imm_i ? imm_i : rs2_val_i;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_wr  = 1'b1;
        case (op_i)
            OP_ADD:  {alu_c, alu_res} = {1'b0, rs1_val_i} + {1'b0, b_op};
            OP_SUB: begin
                alu_res = rs1_val_i - b_op;
                alu_c   = rs1_val_i < b_op;
            end
            OP_AND:  alu_res = rs1_val_i & b_op;
            OP_OR:   alu_res = rs1_val_i | b_op;
            OP_XOR:  alu_res = rs1_val_i ^ b_op;
            OP_SLL:  alu_res = rs1_val_i << b_op[3:0];
            OP_SRL:  alu_res = rs1_val_i >> b_op[3:0];
            OP_SRA:  alu_res = BITS'($signed(rs1_val_i) >>> b_op[3:0]);
            OP_MOV:  alu_res = b_op;
            default: alu_wr  = 1'b0;
        endcase
    end

`ifdef EXEC_MUL_EN
    state_e           state_q, state_d;
    logic [RBITS-1:0] mul_rd_q, mul_rd_d;
    logic             mul_start, mul_done;
    logic [BITS-1:0]  mul_prod;

    assign mul_start     = accept && (op_i == OP_MUL);
    assign issue_ready_o = (state_q == ST_IDLE);

    mul_seq #(.BITS(BITS), .CYCLES(MUL_CYCLES)) u_mul_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .run_i     (run_i),
        .start_i   (mul_start),
        .a_i       (rs1_val_i),
        .b_i       (b_op),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mul_rd_q <= '0;
        end else if (run_i) begin
            state_q  <= state_d;
            mul_rd_q <= mul_rd_d;
        end
    end
`else
    assign issue_ready_o = 1'b1;
`endif

    // we_d defaults low so a held pulse drops after the first run-high cycle
    always_comb begin
        we_d     = 1'b0;
        rd_d     = rd_q;
        rd_din_d = rd_din_q;
        z_d      = z_q;
        n_d      = n_q;
        c_d      = c_q;
        if (accept && alu_wr) begin
            we_d     = 1'b1;
            rd_d     = rd_in_i;
            rd_din_d = alu_res;
            z_d      = (alu_res == '0);
            n_d      = alu_res[BITS-1];
            c_d      = alu_c;
        end
`ifdef EXEC_MUL_EN
        state_d  = state_q;
        mul_rd_d = mul_rd_q;
        if (mul_start) begin
            state_d  = ST_MUL;
            mul_rd_d = rd_in_i;
        end
        if (state_q == ST_MUL && mul_done) begin
            state_d  = ST_IDLE;
            we_d     = 1'b1;
            rd_d     = mul_rd_q;
            rd_din_d = mul_prod;
            z_d      = (mul_prod == '0);
            n_d      = mul_prod[BITS-1];
            c_d      = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            rd_q     <= '0;
            rd_din_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            c_q      <= 1'b0;
        end else if (run_i) begin
            we_q     <= we_d;
            rd_q     <= rd_d;
            rd_din_q <= rd_din_d;
            z_q      <= z_d;
            n_q      <= n_d;
            c_q      <= c_d;
        end
    end

    assign we_o     = we_q;
    assign rd_o     = rd_q;
    assign rd_din_o = rd_din_q;
    assign flag_z_o = z_q;
    assign flag_n_o = n_q;
    assign flag_c_o = c_q;

endmodule
